// File: rtl/game_pkg.sv
// Shared types and constants for the melody game master: FSM states, melody
// geometry and the Galois LFSR step used to build each melody.
package game_pkg;

  localparam int unsigned NOTES  = 8;
  localparam int unsigned NOTE_W = 3;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    GEN   = 3'd2,
    WRITE = 3'd3,
    START = 3'd4,
    PLAY  = 3'd5,
    WIN   = 3'd6,
    LOSE  = 3'd7
  } state_t;

  // One right-shifting Galois step; the mask is applied when bit 0 falls out.
  function automatic logic [15:0] galois_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
  endfunction

endpackage

// File: rtl/melody_lfsr.sv
// 16-bit Galois LFSR that supplies note candidates; it steps only when
// i_advance is high, so the sequence carries over from one game to the next.
module melody_lfsr
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_advance,
  output logic [15:0] o_value
);

  logic [15:0] r_lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= SEED;
    end else if (i_advance) begin
      r_lfsr <= galois_step(r_lfsr);
    end
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/game_pattern_master.sv
// Game-side master: builds an 8-note LFSR melody, loads and starts the game,
// tracks lives and reports WIN/LOSE with a blinking result indicator.
// Optional build macro NO_REPEAT_EN bumps a note that would repeat its predecessor.
module game_pattern_master
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 5000000,
  parameter int unsigned MAX_MISS  = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        miss_in,
  input  logic        game_end_in,
  output logic        game_reset,
  output logic [31:0] data_out,
  output logic        write_enable,
  output logic        game_start,
  output logic [2:0]  lives_out,
  output logic        busy,
  output logic        win,
  output logic        lose,
  output logic        blink,
  output logic [2:0]  dbg_state,
  output logic [15:0] dbg_lfsr
);

  localparam logic [2:0]  LIVES_INIT = MAX_MISS[2:0];
  localparam logic [31:0] TICK_MAX   = TICK_DIV;

  state_t             r_state;
  logic [2:0]         r_k;
  logic [31:0]        r_tick;
  logic               r_start_d;
  logic               r_miss_d;
  logic               r_end_d;

  logic               w_start_edge;
  logic               w_miss_edge;
  logic               w_end_edge;
  logic [15:0]        w_lfsr;
  logic [NOTE_W-1:0]  w_cand;
  logic [NOTE_W-1:0]  w_note;

  assign w_start_edge = start_btn   & ~r_start_d;
  assign w_miss_edge  = miss_in     & ~r_miss_d;
  assign w_end_edge   = game_end_in & ~r_end_d;

  melody_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (reset),
    .i_advance (r_state == GEN),
    .o_value   (w_lfsr)
  );

  assign w_cand = w_lfsr[NOTE_W-1:0];

`ifdef NO_REPEAT_EN
  logic [NOTE_W-1:0] w_prev;
  assign w_prev = data_out[{r_k - 3'd1, 2'b00} +: NOTE_W];
  assign w_note = ((r_k != 3'd0) && (w_cand == w_prev)) ? w_cand + 3'd1 : w_cand;
`else
  assign w_note = w_cand;
`endif

  assign dbg_state = r_state;
  assign dbg_lfsr  = w_lfsr;

  // Status outputs follow the state one cycle later, so every output is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_k          <= 3'd0;
      r_tick       <= 32'd0;
      r_start_d    <= 1'b0;
      r_miss_d     <= 1'b0;
      r_end_d      <= 1'b0;
      game_reset   <= 1'b0;
      data_out     <= 32'd0;
      write_enable <= 1'b0;
      game_start   <= 1'b0;
      lives_out    <= LIVES_INIT;
      busy         <= 1'b0;
      win          <= 1'b0;
      lose         <= 1'b0;
      blink        <= 1'b0;
    end else begin
      r_start_d    <= start_btn;
      r_miss_d     <= miss_in;
      r_end_d      <= game_end_in;
      game_reset   <= (r_state == CLR);
      write_enable <= (r_state == WRITE);
      game_start   <= (r_state == START);
      busy         <= (r_state == CLR) || (r_state == GEN) || (r_state == WRITE) ||
                      (r_state == START) || (r_state == PLAY);
      win          <= (r_state == WIN);
      lose         <= (r_state == LOSE);

      // Blink counter sits at zero outside the result states, so entry starts fresh.
      if ((r_state == WIN) || (r_state == LOSE)) begin
        if (r_tick == TICK_MAX) begin
          r_tick <= 32'd0;
          blink  <= ~blink;
        end else begin
          r_tick <= r_tick + 32'd1;
        end
      end else begin
        r_tick <= 32'd0;
        blink  <= 1'b0;
      end

      case (r_state)
        IDLE, WIN, LOSE: begin
          if (w_start_edge) r_state <= CLR;
        end
        CLR: begin
          lives_out <= LIVES_INIT;
          r_k       <= 3'd0;
          r_state   <= GEN;
        end
        GEN: begin
          data_out[{r_k, 2'b00} +: 4] <= {1'b0, w_note};
          r_k <= r_k + 3'd1;
          if (r_k == 3'(NOTES - 1)) r_state <= WRITE;
        end
        WRITE: r_state <= START;
        START: r_state <= PLAY;
        PLAY: begin
          // A finished melody outranks a simultaneous miss.
          if (w_end_edge) begin
            r_state <= WIN;
          end else if (w_miss_edge) begin
            if (lives_out <= 3'd1) begin
              lives_out <= 3'd0;
              r_state   <= LOSE;
            end else begin
              lives_out <= lives_out - 3'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
